// File: rtl/p4_router_egr_port_shaper_if.sv
// Egress shaper port bundle: configuration writes in, dequeue notifications in,
// per-port eligibility and bad-port error out.
interface p4_router_egr_port_shaper_if #(
  parameter int NUM_EGR_PORTS = 16,
  parameter int TOKEN_W       = 24,
  parameter int RATE_W        = 16,
  parameter int MTU_BYTES     = 2000
) ();
  // One spare index bit so that out-of-range port numbers can be presented and flagged.
  localparam int PORT_W = $clog2(NUM_EGR_PORTS + 1);
  localparam int DEQ_W  = $clog2(MTU_BYTES + 1);

  // cfg_wr_en and deq_valid are single-cycle strobes with no ready/backpressure:
  // the payload beside each strobe is consumed in the cycle the strobe is high.
  logic                     cfg_wr_en;
  logic [PORT_W-1:0]        cfg_port;
  logic                     cfg_enable;
  logic [RATE_W-1:0]        cfg_rate;
  logic [TOKEN_W-2:0]       cfg_burst;
  logic                     deq_valid;
  logic [PORT_W-1:0]        deq_port;
  logic [DEQ_W-1:0]         deq_bytes;
  logic [NUM_EGR_PORTS-1:0] port_eligible;
  logic                     deq_port_err;

  modport master (
    output cfg_wr_en, cfg_port, cfg_enable, cfg_rate, cfg_burst,
    output deq_valid, deq_port, deq_bytes,
    input  port_eligible, deq_port_err
  );

  modport slave (
    input  cfg_wr_en, cfg_port, cfg_enable, cfg_rate, cfg_burst,
    input  deq_valid, deq_port, deq_bytes,
    output port_eligible, deq_port_err
  );
endinterface

// File: rtl/p4_router_egr_port_shaper.sv
// Per-egress-port token-bucket shaper: signed byte credit per port, refilled every
// TICK_DIV cycles, debited on dequeue; registered eligibility towards the scheduler.
module p4_router_egr_port_shaper #(
  parameter int NUM_EGR_PORTS = 16,
  parameter int TOKEN_W       = 24,
  parameter int RATE_W        = 16,
  parameter int TICK_DIV      = 256,
  parameter int MTU_BYTES     = 2000
) (
  input  logic clk,
  input  logic rst,
  p4_router_egr_port_shaper_if.slave bus
);
  localparam int PORT_W = $clog2(NUM_EGR_PORTS + 1);
  localparam int DEQ_W  = $clog2(MTU_BYTES + 1);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic signed [TOKEN_W-1:0] TOK_MIN     = {1'b1, {(TOKEN_W-1){1'b0}}};
  localparam logic signed [TOKEN_W:0]   TOK_MIN_EXT = {2'b11, {(TOKEN_W-1){1'b0}}};

  logic [TICK_W-1:0]         tick_cnt;
  logic                      refill;
  logic                      cfg_hit;
  logic                      deq_hit;

  logic [NUM_EGR_PORTS-1:0]  en_q, en_d;
  logic [RATE_W-1:0]         rate_q  [NUM_EGR_PORTS];
  logic [RATE_W-1:0]         rate_d  [NUM_EGR_PORTS];
  logic [TOKEN_W-2:0]        burst_q [NUM_EGR_PORTS];
  logic [TOKEN_W-2:0]        burst_d [NUM_EGR_PORTS];
  logic signed [TOKEN_W-1:0] tok_q   [NUM_EGR_PORTS];
  logic signed [TOKEN_W-1:0] tok_d   [NUM_EGR_PORTS];
  logic [NUM_EGR_PORTS-1:0]  elig_q, elig_d;
  logic                      err_q;

  // Refill tick: every port gains its rate in the last cycle of each TICK_DIV window.
  assign refill = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (refill) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Out-of-range ports are dropped here so no per-port logic can ever match them.
  assign cfg_hit = bus.cfg_wr_en && (bus.cfg_port < PORT_W'(NUM_EGR_PORTS));
  assign deq_hit = bus.deq_valid && (bus.deq_port < PORT_W'(NUM_EGR_PORTS));

  always_comb begin : token_update
    logic signed [TOKEN_W:0] sum;
    logic signed [TOKEN_W:0] burst_ext;
    sum       = '0;
    burst_ext = '0;
    en_d      = en_q;
    elig_d    = '1;
    for (int p = 0; p < NUM_EGR_PORTS; p++) begin
      rate_d[p]  = rate_q[p];
      burst_d[p] = burst_q[p];
      tok_d[p]   = tok_q[p];

      // One extra bit of headroom so the sum can be compared against both clamps.
      sum = $signed({tok_q[p][TOKEN_W-1], tok_q[p]});
      if (refill) begin
        sum = sum + $signed({{(TOKEN_W + 1 - RATE_W){1'b0}}, rate_q[p]});
      end
      if (deq_hit && (bus.deq_port == PORT_W'(p))) begin
        sum = sum - $signed({{(TOKEN_W + 1 - DEQ_W){1'b0}}, bus.deq_bytes});
      end
      burst_ext = $signed({2'b00, burst_q[p]});

      if (cfg_hit && (bus.cfg_port == PORT_W'(p))) begin
        en_d[p]    = bus.cfg_enable;
        rate_d[p]  = bus.cfg_rate;
        burst_d[p] = bus.cfg_burst;
        tok_d[p]   = $signed({1'b0, bus.cfg_burst});
      end else if (!en_q[p]) begin
        tok_d[p] = $signed({1'b0, burst_q[p]});
      end else if (sum > burst_ext) begin
        tok_d[p] = $signed({1'b0, burst_q[p]});
      end else if (sum < TOK_MIN_EXT) begin
        tok_d[p] = TOK_MIN;
      end else begin
        tok_d[p] = $signed(sum[TOKEN_W-1:0]);
      end

      elig_d[p] = !en_d[p] || !tok_d[p][TOKEN_W-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= '0;
      elig_q <= '1;
      err_q  <= 1'b0;
      for (int p = 0; p < NUM_EGR_PORTS; p++) begin
        rate_q[p]  <= '0;
        burst_q[p] <= '0;
        tok_q[p]   <= '0;
      end
    end else begin
      en_q   <= en_d;
      elig_q <= elig_d;
      err_q  <= bus.deq_valid && !deq_hit;
      for (int p = 0; p < NUM_EGR_PORTS; p++) begin
        rate_q[p]  <= rate_d[p];
        burst_q[p] <= burst_d[p];
        tok_q[p]   <= tok_d[p];
      end
    end
  end

  assign bus.port_eligible = elig_q;
  assign bus.deq_port_err  = err_q;
endmodule
